// File: rtl/blink_rate_decoder.sv
// Purpose: measure the half-period of a looped-back blink waveform and decode which of four rate settings produced it.
// Latency: blink_in change -> edge pulse on the 3rd sysclk edge; decoded outputs register one cycle after the edge pulse.
// Backpressure: none; a free-running observer with no handshake. Every edge is measured and no input is ever stalled.
//
// Ports:
//   sysclk       system clock, all state on the rising edge
//   rst_n        asynchronous active-low reset
//   blink_in     asynchronous blink waveform under observation
//   rate         decoded rate setting (0 fastest .. 3 slowest); keeps its last value when the decode is lost
//   rate_valid   rate holds a confirmed decode
//   rate_change  one-cycle pulse when rate_valid rises or rate takes a new value
//   stalled      no edge seen for STALL_CYCLES cycles
//   half_period  last raw measurement in sysclk cycles
module blink_rate_decoder #(
    parameter int BASE_HALF   = 1024,
    parameter int TOL_SHIFT   = 3,
    parameter int MATCH_COUNT = 2,
    parameter int CNT_W       = 16
) (
    input  logic             sysclk,
    input  logic             rst_n,
    input  logic             blink_in,
    output logic [1:0]       rate,
    output logic             rate_valid,
    output logic             rate_change,
    output logic             stalled,
    output logic [CNT_W-1:0] half_period
);

    // Four times the slowest nominal half-period: comfortably beyond any legal measurement.
    localparam int STALL_CYCLES = 32 * BASE_HALF;
    localparam int STRK_W       = $clog2(MATCH_COUNT + 1);

    localparam logic [CNT_W-1:0]  STALL_LAST  = CNT_W'(STALL_CYCLES - 1);
    localparam logic [STRK_W-1:0] STRK_TARGET = STRK_W'(MATCH_COUNT);

    typedef enum logic [1:0] {
        ST_FIRST   = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_TRACK   = 2'd2
    } state_t;

    state_t state, state_nxt;

    // ------------------------------------------------------------------
    // Input path: two-flop synchronizer plus a delay flop for edge detect.
    // ------------------------------------------------------------------
    logic sync_q1, sync_q2, dly_q;
    logic edge_det;

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            dly_q   <= 1'b0;
        end else begin
            sync_q1 <= blink_in;
            sync_q2 <= sync_q1;
            dly_q   <= sync_q2;
        end
    end

    // Both polarities count: every transition ends one half-period.
    assign edge_det = sync_q2 ^ dly_q;

    // ------------------------------------------------------------------
    // Half-period counter. Cleared on the edge cycle, so at the next edge
    // cnt is one short of the true spacing; the measurement adds it back.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (edge_det) begin
            cnt <= '0;
        end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
        end
    end

    // One extra bit so a saturated counter cannot wrap the measurement.
    logic [CNT_W:0]   meas;
    logic [CNT_W-1:0] meas_sat;

    assign meas     = {1'b0, cnt} + (CNT_W + 1)'(1);
    assign meas_sat = meas[CNT_W] ? '1 : meas[CNT_W-1:0];

    // ------------------------------------------------------------------
    // Classification: window k is N_k +/- (N_k >> TOL_SHIFT).
    // ------------------------------------------------------------------
    logic [3:0] in_win;

    for (genvar k = 0; k < 4; k++) begin : g_cls
        localparam logic [CNT_W:0] NOM = (CNT_W + 1)'(BASE_HALF << k);
        localparam logic [CNT_W:0] TOL = NOM >> TOL_SHIFT;

        logic [CNT_W:0] diff;

        assign diff      = (meas >= NOM) ? (meas - NOM) : (NOM - meas);
        assign in_win[k] = (diff <= TOL);
    end

    logic       cls_hit;
    logic [1:0] cls;

    // Later assignments override earlier ones, so the lowest matching class wins.
    always_comb begin
        cls_hit = |in_win;
        cls     = 2'd0;
        if (in_win[3]) cls = 2'd3;
        if (in_win[2]) cls = 2'd2;
        if (in_win[1]) cls = 2'd1;
        if (in_win[0]) cls = 2'd0;
    end

    // ------------------------------------------------------------------
    // Event decode.
    // ------------------------------------------------------------------
    logic              stall_evt;
    logic              meas_evt;
    logic [STRK_W-1:0] streak, streak_nxt;
    logic [1:0]        prev_cls, prev_cls_nxt;
    logic              same_cls;
    logic [STRK_W-1:0] streak_inc;
    logic              promote;

    // An edge landing on the threshold cycle wins: no stall in that case.
    assign stall_evt = !edge_det && (cnt == STALL_LAST);

    // The first edge after reset or a stall only starts the counter.
    assign meas_evt = edge_det && (state != ST_FIRST);

    // A zero streak means "no previous class", even if prev_cls happens to match.
    assign same_cls   = cls_hit && (streak != '0) && (cls == prev_cls);
    assign streak_inc = same_cls ? (streak + 1'b1) : STRK_W'(1);
    assign promote    = cls_hit && (streak_inc >= STRK_TARGET);

    // ------------------------------------------------------------------
    // FSM: state register.
    // ------------------------------------------------------------------
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_FIRST;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_FIRST: begin
                if (edge_det) state_nxt = ST_ACQUIRE;
            end
            ST_ACQUIRE: begin
                if (stall_evt)                state_nxt = ST_FIRST;
                else if (meas_evt && promote) state_nxt = ST_TRACK;
            end
            ST_TRACK: begin
                if (stall_evt)                 state_nxt = ST_FIRST;
                else if (meas_evt && !cls_hit) state_nxt = ST_ACQUIRE;
            end
            default: state_nxt = ST_FIRST;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output / datapath next values.
    // ------------------------------------------------------------------
    logic [1:0]       rate_nxt;
    logic             rate_valid_nxt;
    logic             rate_change_nxt;
    logic             stalled_nxt;
    logic [CNT_W-1:0] half_period_nxt;

    always_comb begin
        rate_nxt        = rate;
        rate_valid_nxt  = rate_valid;
        rate_change_nxt = 1'b0;
        stalled_nxt     = stalled;
        half_period_nxt = half_period;
        streak_nxt      = streak;
        prev_cls_nxt    = prev_cls;

        if (edge_det) begin
            stalled_nxt = 1'b0;
        end

        if (stall_evt) begin
            stalled_nxt    = 1'b1;
            rate_valid_nxt = 1'b0;
            streak_nxt     = '0;
        end

        if (meas_evt) begin
            // Unmatched measurements are still reported.
            half_period_nxt = meas_sat;

            if (!cls_hit) begin
                streak_nxt     = '0;
                rate_valid_nxt = 1'b0;
            end else if (state == ST_TRACK && cls == rate) begin
                // Confirms the current rate and breaks any competing streak.
                streak_nxt   = '0;
                prev_cls_nxt = rate;
            end else begin
                prev_cls_nxt = cls;
                if (promote) begin
                    // In ACQUIRE rate_valid is low, so this is always a rise;
                    // in TRACK cls differs from rate, so this is always a new value.
                    rate_nxt        = cls;
                    rate_valid_nxt  = 1'b1;
                    rate_change_nxt = 1'b1;
                    streak_nxt      = '0;
                end else begin
                    streak_nxt = streak_inc;
                end
            end
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            rate        <= 2'd0;
            rate_valid  <= 1'b0;
            rate_change <= 1'b0;
            stalled     <= 1'b0;
            half_period <= '0;
            streak      <= '0;
            prev_cls    <= 2'd0;
        end else begin
            rate        <= rate_nxt;
            rate_valid  <= rate_valid_nxt;
            rate_change <= rate_change_nxt;
            stalled     <= stalled_nxt;
            half_period <= half_period_nxt;
            streak      <= streak_nxt;
            prev_cls    <= prev_cls_nxt;
        end
    end

endmodule

// File: tb/tb_blink_rate_decoder.sv
// Purpose: self-checking bench for blink_rate_decoder with BASE_HALF=16 (N = 16/32/64/128, stall at 512).
// Latency: each toggle is expected to show on the outputs 3 sysclk edges later; a scoreboard holds the due cycle.
// Backpressure: none; stimulus is free-running square-wave segments plus hand-built corner sequences.
module tb_blink_rate_decoder;

    logic        sysclk = 1'b0;
    logic        rst_n;
    logic        blink_in;
    logic [1:0]  rate;
    logic        rate_valid;
    logic        rate_change;
    logic        stalled;
    logic [15:0] half_period;

    blink_rate_decoder #(
        .BASE_HALF  (16),
        .TOL_SHIFT  (3),
        .MATCH_COUNT(2),
        .CNT_W      (16)
    ) dut (
        .sysclk     (sysclk),
        .rst_n      (rst_n),
        .blink_in   (blink_in),
        .rate       (rate),
        .rate_valid (rate_valid),
        .rate_change(rate_change),
        .stalled    (stalled),
        .half_period(half_period)
    );

    always #5 sysclk = ~sysclk;

    int cyc = 0;
    always @(posedge sysclk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        bit          chg_only;
        logic [15:0] hp;
        logic [1:0]  rate;
        logic        vld;
        logic        chg;
        logic        stl;
        string       name;
    } exp_t;

    typedef struct {
        int          gap;
        logic [15:0] hp;
        logic [1:0]  rate;
        logic        vld;
        logic        chg;
    } vec_t;

    exp_t sbq[$];
    vec_t vecs[21];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   r0;
    int   t_last;

    task automatic push(int due, bit chg_only, logic [15:0] hp, logic [1:0] r,
                        logic v, logic c, logic s, string nm);
        exp_t e;
        e.due      = due;
        e.chg_only = chg_only;
        e.hp       = hp;
        e.rate     = r;
        e.vld      = v;
        e.chg      = c;
        e.stl      = s;
        e.name     = nm;
        sbq.push_back(e);
    endtask

    task automatic chk(exp_t e);
        n_cmp++;
        if (e.chg_only) begin
            if (rate_change !== 1'b0) begin
                n_fail++;
                $display("FAIL %s: rate_change=%b, required 0 (pulse must last one cycle)", e.name, rate_change);
            end
        end else if ({half_period, rate, rate_valid, rate_change, stalled} !==
                     {e.hp, e.rate, e.vld, e.chg, e.stl}) begin
            n_fail++;
            $display("FAIL %s: got hp=%0d rate=%0d vld=%b chg=%b stl=%b, required hp=%0d rate=%0d vld=%b chg=%b stl=%b",
                     e.name, half_period, rate, rate_valid, rate_change, stalled,
                     e.hp, e.rate, e.vld, e.chg, e.stl);
        end
    endtask

    // Pops every record whose due cycle has arrived, sampling on the falling edge.
    task automatic monitor();
        forever begin
            @(negedge sysclk);
            for (int i = sbq.size() - 1; i >= 0; i--) begin
                if (sbq[i].due == cyc) begin
                    chk(sbq[i]);
                    sbq.delete(i);
                end
            end
        end
    endtask

    // Toggle blink_in `gap` cycles after the previous toggle and book the expected result.
    task automatic tog(int gap, logic [15:0] hp, logic [1:0] r, logic v, logic c, string nm);
        repeat (gap) @(negedge sysclk);
        blink_in = ~blink_in;
        push(cyc + 3, 1'b0, hp, r, v, c, 1'b0, nm);
        if (c) push(cyc + 4, 1'b1, hp, r, v, 1'b0, 1'b0, {nm, "_pulse_end"});
    endtask

    task automatic chk_zero(string nm);
        n_cmp++;
        if ({half_period, rate, rate_valid, rate_change, stalled} !== 21'd0) begin
            n_fail++;
            $display("FAIL %s: got hp=%0d rate=%0d vld=%b chg=%b stl=%b, required all zero",
                     nm, half_period, rate, rate_valid, rate_change, stalled);
        end
    endtask

    initial begin
        // gap, half_period, rate, rate_valid, rate_change after each toggle
        vecs[0]  = '{5,   16'd0,   2'd0, 1'b0, 1'b0};  // first edge: unmeasured
        vecs[1]  = '{16,  16'd16,  2'd0, 1'b0, 1'b0};
        vecs[2]  = '{16,  16'd16,  2'd0, 1'b1, 1'b1};  // acquire rate 0
        vecs[3]  = '{16,  16'd16,  2'd0, 1'b1, 1'b0};
        vecs[4]  = '{64,  16'd64,  2'd0, 1'b1, 1'b0};  // one 64: rate held
        vecs[5]  = '{64,  16'd64,  2'd2, 1'b1, 1'b1};  // second 64: switch
        vecs[6]  = '{64,  16'd64,  2'd2, 1'b1, 1'b0};
        vecs[7]  = '{34,  16'd34,  2'd2, 1'b1, 1'b0};
        vecs[8]  = '{34,  16'd34,  2'd1, 1'b1, 1'b1};
        vecs[9]  = '{37,  16'd37,  2'd1, 1'b0, 1'b0};  // outside 32+/-4
        vecs[10] = '{28,  16'd28,  2'd1, 1'b0, 1'b0};  // lower edge of window
        vecs[11] = '{28,  16'd28,  2'd1, 1'b1, 1'b1};
        vecs[12] = '{128, 16'd128, 2'd1, 1'b1, 1'b0};
        vecs[13] = '{128, 16'd128, 2'd3, 1'b1, 1'b1};
        vecs[14] = '{144, 16'd144, 2'd3, 1'b1, 1'b0};  // upper edge 128+16
        vecs[15] = '{145, 16'd145, 2'd3, 1'b0, 1'b0};  // just outside
        vecs[16] = '{14,  16'd14,  2'd3, 1'b0, 1'b0};  // lower edge 16-2
        vecs[17] = '{14,  16'd14,  2'd0, 1'b1, 1'b1};
        vecs[18] = '{13,  16'd13,  2'd0, 1'b0, 1'b0};  // just outside
        vecs[19] = '{128, 16'd128, 2'd0, 1'b0, 1'b0};
        vecs[20] = '{128, 16'd128, 2'd3, 1'b1, 1'b1};

        fork
            monitor();
        join_none

        // Asynchronous reset with no clock edge in between.
        rst_n    = 1'b1;
        blink_in = 1'b0;
        #1 rst_n = 1'b0;
        #1 chk_zero("reset_state");

        repeat (3) @(negedge sysclk);
        rst_n = 1'b1;
        r0    = cyc;

        // Input held constant from reset stalls after 512 cycles.
        push(r0 + 511, 1'b0, 16'd0, 2'd0, 1'b0, 1'b0, 1'b0, "idle_before_stall");
        push(r0 + 512, 1'b0, 16'd0, 2'd0, 1'b0, 1'b0, 1'b1, "idle_stall");
        repeat (515) @(negedge sysclk);

        for (int i = 0; i < 21; i++) begin
            tog(vecs[i].gap, vecs[i].hp, vecs[i].rate, vecs[i].vld, vecs[i].chg,
                $sformatf("vec%0d", i));
        end

        // Stall while tracking rate 3: stalled rises 512 cycles after the last edge pulse.
        t_last = cyc;
        push(t_last + 514, 1'b0, 16'd128, 2'd3, 1'b1, 1'b0, 1'b0, "stall_before");
        push(t_last + 515, 1'b0, 16'd128, 2'd3, 1'b0, 1'b0, 1'b1, "stall_set");
        tog(600, 16'd128, 2'd3, 1'b0, 1'b0, "resume_edge1");
        tog(128, 16'd128, 2'd3, 1'b0, 1'b0, "resume_edge2");
        tog(128, 16'd128, 2'd3, 1'b1, 1'b1, "resume_edge3");

        // Reset between edges while rate_valid is high.
        repeat (20) @(negedge sysclk);
        #2 rst_n = 1'b0;
        #1 chk_zero("reset_mid_op");
        blink_in = 1'b0;
        repeat (3) @(negedge sysclk);
        rst_n = 1'b1;
        tog(5,  16'd0,  2'd0, 1'b0, 1'b0, "reacq_first");
        tog(32, 16'd32, 2'd0, 1'b0, 1'b0, "reacq_edge2");
        tog(32, 16'd32, 2'd1, 1'b1, 1'b1, "reacq_edge3");

        // One-cycle glitch in an H=32 wave.
        tog(32, 16'd32, 2'd1, 1'b1, 1'b0, "glitch_pre");
        tog(1,  16'd1,  2'd1, 1'b0, 1'b0, "glitch_pulse");
        tog(31, 16'd31, 2'd1, 1'b0, 1'b0, "glitch_tail");
        tog(32, 16'd32, 2'd1, 1'b1, 1'b1, "glitch_recover");

        repeat (10) @(negedge sysclk);
        n_cmp++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d records left, required 0", sbq.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
